// File: rtl/axi_mm2s_reader.sv
// Memory-to-stream read engine: splits a command into AXI4 INCR bursts (MAX_BURST / 4 KB limits)
// and forwards R beats as one AXI-stream packet. One burst outstanding at a time.
module axi_mm2s_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [LEN_WIDTH-1:0]      cmd_beats,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  input  logic                      RVALID,
  output logic                      RREADY,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  output logic                      TVALID,
  input  logic                      TREADY,
  output logic [DATA_WIDTH-1:0]     TDATA,
  output logic [DATA_WIDTH/8-1:0]   TSTRB,
  output logic                      TLAST,
  output logic                      TUSER
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BYTES);
  localparam int CW       = LEN_WIDTH + 14;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic                  err_acc_q, err_acc_d;
  logic                  first_q, first_d;

  logic [CW-1:0]         room;
  logic [CW-1:0]         burst_w;
  logic [8:0]            burst;
  logic                  unused_ok;

  // RLAST and RRESP[0] carry no information here: the local beat count is authoritative.
  assign unused_ok = ^{RLAST, RRESP[0]};

  always_comb begin
    room    = CW'((13'h1000 - {1'b0, addr_q[11:0]}) >> OFF_BITS);
    burst_w = CW'(rem_q);
    if (CW'(MAX_BURST) < burst_w) burst_w = CW'(MAX_BURST);
    if (room < burst_w)           burst_w = room;
    burst = burst_w[8:0];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      beat_cnt_q <= '0;
      err_acc_q  <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      beat_cnt_q <= beat_cnt_d;
      err_acc_q  <= err_acc_d;
      first_q    <= first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    beat_cnt_d = beat_cnt_q;
    err_acc_d  = err_acc_q;
    first_d    = first_q;
    cmd_ready  = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    err        = 1'b0;
    ARVALID    = 1'b0;
    ARADDR     = '0;
    ARLEN      = '0;
    ARSIZE     = '0;
    ARBURST    = '0;
    RREADY     = 1'b0;
    TVALID     = 1'b0;
    TDATA      = '0;
    TSTRB      = '0;
    TLAST      = 1'b0;
    TUSER      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d    = cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
          rem_d     = cmd_beats;
          err_acc_d = 1'b0;
          first_d   = 1'b1;
          state_d   = (cmd_beats == '0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        ARVALID = 1'b1;
        ARADDR  = addr_q;
        ARLEN   = 8'(burst - 9'd1);
        ARSIZE  = 3'(OFF_BITS);
        ARBURST = 2'b01;
        if (ARREADY) begin
          beat_cnt_d = burst;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        TVALID = RVALID;
        RREADY = TREADY;
        TDATA  = RDATA;
        TSTRB  = '1;
        TLAST  = (rem_q == LEN_WIDTH'(1));
        TUSER  = first_q;
        if (RVALID && TREADY) begin
          // Address advances per beat; it equals addr + burst*BYTES once the burst ends.
          addr_d     = addr_q + ADDR_WIDTH'(BYTES);
          rem_d      = rem_q - LEN_WIDTH'(1);
          beat_cnt_d = beat_cnt_q - 9'd1;
          first_d    = 1'b0;
          if (RRESP[1]) err_acc_d = 1'b1;
          if (beat_cnt_q == 9'd1) state_d = (rem_q == LEN_WIDTH'(1)) ? S_DONE : S_ADDR;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        err     = err_acc_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
